// File: rtl/bist_misr_checker.sv
// BIST response compactor: folds PATTERNS response words into a MISR,
// then compares the final signature against a golden value.
//
// Ports:
//   clk, rst (async active-low)
//   start          : seed the MISR and begin (or restart) a run
//   resp_valid     : qualifies resp_data
//   resp_data      : response word to compact
//   golden         : expected signature, sampled in COMPARE
//   busy, done     : run status (COMPACT/COMPARE, DONE)
//   pass, fail     : verdict, valid while done is high
//   signature      : current MISR contents
//   count          : responses accepted in this run
module bist_misr_checker #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   POLY     = 32'h04C11DB7,
    parameter logic [WIDTH-1:0]   SEED     = 32'hFFFFFFFF,
    parameter int                 PATTERNS = 16,
    localparam int                CW       = $clog2(PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [WIDTH-1:0] signature,
    output logic [CW-1:0]    count
);

    typedef enum logic [1:0] {
        IDLE,
        COMPACT,
        COMPARE,
        FINISH
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_step;
    logic [CW-1:0]    cnt_q;
    logic             pass_q;
    logic             fail_q;
    logic             accept;
    logic             last;

    // Shift left, fold the dropped MSB back through the taps, absorb input.
    assign sig_step = {sig_q[WIDTH-2:0], 1'b0}
                    ^ (sig_q[WIDTH-1] ? POLY : '0)
                    ^ resp_data;

    assign accept = (state_q == COMPACT) && resp_valid && !start;
    assign last   = (cnt_q == CW'(PATTERNS - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = COMPACT;
            COMPACT: begin
                if (start)
                    state_d = COMPACT;
                else if (resp_valid && last)
                    state_d = COMPARE;
            end
            COMPARE: state_d = start ? COMPACT : FINISH;
            FINISH:  if (start) state_d = COMPACT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                // Any start reseeds; a coincident response is dropped.
                sig_q  <= SEED;
                cnt_q  <= '0;
                pass_q <= 1'b0;
                fail_q <= 1'b0;
            end else if (accept) begin
                sig_q <= sig_step;
                cnt_q <= cnt_q + CW'(1);
            end else if (state_q == COMPARE) begin
                pass_q <= (sig_q == golden);
                fail_q <= (sig_q != golden);
            end
        end
    end

    assign busy      = (state_q == COMPACT) || (state_q == COMPARE);
    assign done      = (state_q == FINISH);
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign signature = sig_q;
    assign count     = cnt_q;

endmodule
